// File: rtl/counter_step_monitor_if.sv
// counter_step_monitor_if: observed counter signals and checker results
interface counter_step_monitor_if #(
  parameter int CNT_WIDTH = 8
);
  logic [3:0]           q;
  logic                 up_down;
  logic                 step_error;
  logic [3:0]           error_value;
  logic [CNT_WIDTH-1:0] error_count;
  logic                 wrap_pulse;
  logic                 wrap_dir;
  logic [CNT_WIDTH-1:0] wrap_count;
  logic                 tracking;
  modport master (
    output q, up_down,
    input  step_error, error_value, error_count, wrap_pulse, wrap_dir, wrap_count, tracking
  );
  modport slave (
    input  q, up_down,
    output step_error, error_value, error_count, wrap_pulse, wrap_dir, wrap_count, tracking
  );
endinterface

// File: rtl/counter_step_monitor.sv
// counter_step_monitor: checks each counter sample is one step (mod 16) in the captured direction
module counter_step_monitor #(
  parameter int CNT_WIDTH    = 8,
  parameter bit STICKY_ERROR = 1'b1
) (
  input  logic                   clock_signal,
  input  logic                   reset_signal,
  counter_step_monitor_if.slave  mon
);
  typedef enum logic {SYNC, TRACK} state_t;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  state_t               state, state_nxt;
  logic [3:0]           prev_q, expected, error_value, error_value_nxt;
  logic                 prev_dir, mismatch, good, wrap;
  logic                 step_error, step_error_nxt, wrap_pulse, wrap_dir, wrap_dir_nxt;
  logic [CNT_WIDTH-1:0] error_count, error_count_nxt, wrap_count, wrap_count_nxt;
  always_comb begin
    state_nxt       = TRACK;
    expected        = prev_dir ? prev_q + 4'd1 : prev_q - 4'd1;
    mismatch        = (state == TRACK) && (mon.q != expected);
    good            = (state == TRACK) && (mon.q == expected);
    // a correct step out of 15 (up) or 0 (down) is necessarily the wrap
    wrap            = good && (prev_dir ? prev_q == 4'hf : prev_q == 4'h0);
    step_error_nxt  = mismatch ? 1'b1 : (good && !STICKY_ERROR) ? 1'b0 : step_error;
    error_value_nxt = mismatch ? mon.q : error_value;
    error_count_nxt = (mismatch && error_count != CNT_MAX) ? error_count + 1'b1 : error_count;
    wrap_dir_nxt    = wrap ? prev_dir : wrap_dir;
    wrap_count_nxt  = (wrap && wrap_count != CNT_MAX) ? wrap_count + 1'b1 : wrap_count;
  end
  always_ff @(posedge clock_signal) begin
    if (reset_signal) begin
      state       <= SYNC;
      prev_q      <= '0;
      prev_dir    <= 1'b0;
      step_error  <= 1'b0;
      error_value <= '0;
      error_count <= '0;
      wrap_pulse  <= 1'b0;
      wrap_dir    <= 1'b0;
      wrap_count  <= '0;
    end else begin
      state       <= state_nxt;
      prev_q      <= mon.q;
      prev_dir    <= mon.up_down;
      step_error  <= step_error_nxt;
      error_value <= error_value_nxt;
      error_count <= error_count_nxt;
      wrap_pulse  <= wrap;
      wrap_dir    <= wrap_dir_nxt;
      wrap_count  <= wrap_count_nxt;
    end
  end
  assign mon.step_error  = step_error;
  assign mon.error_value = error_value;
  assign mon.error_count = error_count;
  assign mon.wrap_pulse  = wrap_pulse;
  assign mon.wrap_dir    = wrap_dir;
  assign mon.wrap_count  = wrap_count;
  assign mon.tracking    = (state == TRACK);
endmodule

// File: tb/tb_counter_step_monitor.sv
// tb_counter_step_monitor: table-driven vectors for the sticky/8-bit build, hand sequence for pulse/2-bit build
module tb_counter_step_monitor;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  counter_step_monitor_if #(.CNT_WIDTH(8)) a_if ();
  counter_step_monitor_if #(.CNT_WIDTH(2)) b_if ();
  counter_step_monitor #(.CNT_WIDTH(8), .STICKY_ERROR(1'b1)) dut_a (
    .clock_signal(clk), .reset_signal(rst_a), .mon(a_if.slave));
  counter_step_monitor #(.CNT_WIDTH(2), .STICKY_ERROR(1'b0)) dut_b (
    .clock_signal(clk), .reset_signal(rst_b), .mon(b_if.slave));
  typedef struct {
    logic       rst;
    logic [3:0] q;
    logic       ud;
    logic       err;
    logic [3:0] ev;
    logic [7:0] ec;
    logic       wp;
    logic       wd;
    logic [7:0] wc;
    logic       tr;
  } vec_t;
  vec_t vecs[$];
  task automatic v(input logic rst, input logic [3:0] q, input logic ud, input logic err,
                   input logic [3:0] ev, input logic [7:0] ec, input logic wp, input logic wd,
                   input logic [7:0] wc, input logic tr);
    vec_t e;
    e.rst = rst; e.q = q; e.ud = ud; e.err = err; e.ev = ev; e.ec = ec;
    e.wp = wp; e.wd = wd; e.wc = wc; e.tr = tr;
    vecs.push_back(e);
  endtask
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, act, exp);
    end
  endtask
  task automatic step_b(input int idx, input logic [3:0] q, input logic ud, input logic err,
                        input logic [3:0] ev, input logic [1:0] ec, input logic tr);
    b_if.q = q;
    b_if.up_down = ud;
    @(posedge clk);
    #1;
    chk("b_step_error", idx, 32'(b_if.step_error), 32'(err));
    chk("b_error_value", idx, 32'(b_if.error_value), 32'(ev));
    chk("b_error_count", idx, 32'(b_if.error_count), 32'(ec));
    chk("b_wrap_count", idx, 32'(b_if.wrap_count), 32'd0);
    chk("b_tracking", idx, 32'(b_if.tracking), 32'(tr));
  endtask
  initial begin
    a_if.q = '0; a_if.up_down = 1'b1;
    b_if.q = '0; b_if.up_down = 1'b1;
    // free-running up count with one wrap
    v(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) v(0, 4'(i), 1, 0, 0, 0, 0, 0, 0, 1);
    v(0, 0, 1, 0, 0, 0, 1, 1, 1, 1);
    for (int i = 1; i < 4; i++) v(0, 4'(i), 1, 0, 0, 0, 0, 1, 1, 1);
    // down count 0,15..0 with one wrap
    v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    v(0, 15, 0, 0, 0, 0, 1, 0, 1, 1);
    for (int i = 14; i >= 0; i--) v(0, 4'(i), 0, 0, 0, 0, 0, 0, 1, 1);
    // reversal 4,5,6,5,4 with up_down dropped alongside q=6
    v(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    v(0, 4, 1, 0, 0, 0, 0, 0, 0, 1);
    v(0, 5, 1, 0, 0, 0, 0, 0, 0, 1);
    v(0, 6, 0, 0, 0, 0, 0, 0, 0, 1);
    v(0, 5, 0, 0, 0, 0, 0, 0, 0, 1);
    v(0, 4, 0, 0, 0, 0, 0, 0, 0, 1);
    // sticky error on 3->7, then a mismatch landing on 0 that is not a wrap
    v(1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    v(0, 2, 1, 0, 0, 0, 0, 0, 0, 1);
    v(0, 3, 1, 0, 0, 0, 0, 0, 0, 1);
    v(0, 7, 1, 1, 7, 1, 0, 0, 0, 1);
    v(0, 8, 1, 1, 7, 1, 0, 0, 0, 1);
    v(0, 9, 1, 1, 7, 1, 0, 0, 0, 1);
    v(0, 0, 1, 1, 0, 2, 0, 0, 0, 1);
    for (int i = 1; i < 16; i++) v(0, 4'(i), 1, 1, 0, 2, 0, 0, 0, 1);
    v(0, 0, 1, 1, 0, 2, 1, 1, 1, 1);
    v(0, 1, 0, 1, 0, 2, 0, 1, 1, 1);
    v(0, 0, 0, 1, 0, 2, 0, 1, 1, 1);
    v(0, 15, 0, 1, 0, 2, 1, 0, 2, 1);
    // mid-run reset clears counts and sticky error
    v(1, 15, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 5, 1, 0, 0, 0, 0, 0, 0, 1);
    v(0, 6, 1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < vecs.size(); i++) begin
      rst_a = vecs[i].rst;
      a_if.q = vecs[i].q;
      a_if.up_down = vecs[i].ud;
      @(posedge clk);
      #1;
      chk("step_error", i, 32'(a_if.step_error), 32'(vecs[i].err));
      chk("error_value", i, 32'(a_if.error_value), 32'(vecs[i].ev));
      chk("error_count", i, 32'(a_if.error_count), 32'(vecs[i].ec));
      chk("wrap_pulse", i, 32'(a_if.wrap_pulse), 32'(vecs[i].wp));
      chk("wrap_dir", i, 32'(a_if.wrap_dir), 32'(vecs[i].wd));
      chk("wrap_count", i, 32'(a_if.wrap_count), 32'(vecs[i].wc));
      chk("tracking", i, 32'(a_if.tracking), 32'(vecs[i].tr));
    end
    // pulse-mode build: five mismatches, 2-bit count saturates at 3
    rst_b = 1'b1;
    step_b(0, 0, 1, 0, 0, 0, 0);
    rst_b = 1'b0;
    step_b(1, 0, 1, 0, 0, 0, 1);
    step_b(2, 1, 1, 0, 0, 0, 1);
    step_b(3, 3, 1, 1, 3, 1, 1);
    step_b(4, 4, 1, 0, 3, 1, 1);
    step_b(5, 9, 1, 1, 9, 2, 1);
    step_b(6, 11, 1, 1, 11, 3, 1);
    step_b(7, 12, 1, 0, 11, 3, 1);
    step_b(8, 0, 1, 1, 0, 3, 1);
    step_b(9, 5, 1, 1, 5, 3, 1);
    step_b(10, 6, 1, 0, 5, 3, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
